// File: rtl/receive_adc_multi.sv
// Multi-lane serial ADC receiver: one shared adc_sclk/adc_cs_n drives N_CH converters,
// each lane is shifted into its own frame register, and completed frames are offered on a
// valid/ready output with overrun reporting when the consumer has not taken the last result.
module receive_adc_multi #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned QUIET_CYC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont_en,
  input  logic [N_CH-1:0]          sdata,
  output logic                     adc_sclk,
  output logic                     adc_cs_n,
  output logic [N_CH*DATA_W-1:0]   dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     overrun,
  output logic                     busy
);

  // One counter serves the setup/half-period divider and the quiet gap.
  localparam int unsigned CntMax = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);

  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] QuietLast = CntW'(QUIET_CYC - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

  state_e                state_q;
  logic [CntW-1:0]       div_cnt_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [FRAME_BITS-1:0] shreg_q [N_CH];

  assign busy = (state_q != StIdle);

  // Frame sequencer, serial clock generation, lane capture and output handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      adc_sclk   <= 1'b1;
      adc_cs_n   <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        shreg_q[i] <= '0;
      end
    end else begin
      overrun <= 1'b0;
      // A consumed result clears valid; a completing frame below may reload it.
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start || cont_en) begin
            state_q   <= StSetup;
            adc_cs_n  <= 1'b0;
            adc_sclk  <= 1'b1;
            div_cnt_q <= '0;
          end
        end

        StSetup: begin
          if (div_cnt_q == DivLast) begin
            state_q   <= StShift;
            adc_sclk  <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + CntW'(1);
          end
        end

        StShift: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            if (!adc_sclk) begin
              // Rising edge sits mid-bit: capture every lane here.
              adc_sclk <= 1'b1;
              for (int unsigned i = 0; i < N_CH; i++) begin
                shreg_q[i] <= (shreg_q[i] << 1) | FRAME_BITS'(sdata[i]);
              end
            end else if (bit_cnt_q == BitLast) begin
              // Last high half-period done: sclk stays high into the quiet gap.
              state_q  <= StQuiet;
              adc_cs_n <= 1'b1;
              if (!dout_valid || dout_ready) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                  dout[i*DATA_W +: DATA_W] <= shreg_q[i][DATA_W-1:0];
                end
                dout_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
              adc_sclk  <= 1'b0;
            end
          end else begin
            div_cnt_q <= div_cnt_q + CntW'(1);
          end
        end

        StQuiet: begin
          if (div_cnt_q == QuietLast) begin
            div_cnt_q <= '0;
            if (cont_en) begin
              state_q  <= StSetup;
              adc_cs_n <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            div_cnt_q <= div_cnt_q + CntW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_receive_adc_multi.sv
// Directed bench for receive_adc_multi: a default-parameter instance plus a narrow,
// fast-clocked single-lane instance, each fed by a behavioural ADC serial model.
module tb_receive_adc_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont_en;
  logic [1:0]  sdata = '0;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic [23:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;
  logic        busy;

  logic        p_start;
  logic        p_cont_en;
  logic [0:0]  p_sdata = '0;
  logic        p_sclk;
  logic        p_cs_n;
  logic [15:0] p_dout;
  logic        p_valid;
  logic        p_ready;
  logic        p_overrun;
  logic        p_busy;

  logic [15:0] w0, w1, pw;
  int          k = 0;
  int          pk = 0;
  int          rises = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  receive_adc_multi dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont_en    (cont_en),
    .sdata      (sdata),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  receive_adc_multi #(
    .DATA_W     (16),
    .FRAME_BITS (16),
    .N_CH       (1),
    .CLK_DIV    (1),
    .QUIET_CYC  (8)
  ) dut_p (
    .clk        (clk),
    .rst        (rst),
    .start      (p_start),
    .cont_en    (p_cont_en),
    .sdata      (p_sdata),
    .adc_sclk   (p_sclk),
    .adc_cs_n   (p_cs_n),
    .dout       (p_dout),
    .dout_valid (p_valid),
    .dout_ready (p_ready),
    .overrun    (p_overrun),
    .busy       (p_busy)
  );

  // ADC model: chip-select fall restarts the word, each sclk fall presents the next bit.
  always @(negedge adc_cs_n or negedge adc_sclk) begin
    if (adc_sclk) begin
      k = 0;
    end else begin
      if (k < 16) begin
        sdata[0] = w0[15-k];
        sdata[1] = w1[15-k];
      end
      k++;
    end
  end

  always @(negedge p_cs_n or negedge p_sclk) begin
    if (p_sclk) begin
      pk = 0;
    end else begin
      if (pk < 16) p_sdata[0] = pw[15-pk];
      pk++;
    end
  end

  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) rises++;

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s idle timeout: busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cont_en = 1'b0; dout_ready = 1'b0;
    p_start = 1'b0; p_cont_en = 1'b0; p_ready = 1'b0;
    w0 = '0; w1 = '0; pw = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({adc_cs_n, adc_sclk, dout_valid, overrun, busy} !== 5'b11000) begin
      bad++;
      $display("FAIL reset ctrl: cs_n,sclk,valid,ovr,busy=%b want 11000",
               {adc_cs_n, adc_sclk, dout_valid, overrun, busy});
    end
    total++;
    if (dout !== 24'h0) begin bad++; $display("FAIL reset dout: got %h want 000000", dout); end
    @(negedge clk) rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin
      bad++; $display("FAIL idle after reset: busy=%b cs_n=%b want 0 1", busy, adc_cs_n);
    end
  endtask

  task automatic test_single();
    int n = 0;
    int r0;
    w0 = 16'h0AC3; w1 = 16'hF53C;
    r0 = rises;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (dout_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != 132) begin bad++; $display("FAIL single latency: got %0d want 132", n); end
    total++;
    if (dout !== 24'h53CAC3) begin bad++; $display("FAIL single dout: got %h want 53cac3", dout); end
    total++;
    if (rises - r0 != 16) begin bad++; $display("FAIL sclk rises: got %0d want 16", rises - r0); end
    total++;
    if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL quiet lines: cs_n,sclk,busy=%b%b%b want 111", adc_cs_n, adc_sclk, busy);
    end
    @(negedge clk) dout_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dout_valid !== 1'b0 || dout !== 24'h53CAC3) begin
      bad++; $display("FAIL single consume: valid=%b dout=%h want 0 53cac3", dout_valid, dout);
    end
    dout_ready = 1'b0;
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    logic [15:0] t0 [3] = '{16'h1234, 16'hA5A5, 16'h8001};
    logic [15:0] t1 [3] = '{16'hFEDC, 16'h0F0F, 16'h7FFE};
    logic [23:0] ex [3] = '{24'hEDC234, 24'hF0F5A5, 24'hFFE001};
    int stamp [3];
    int n = 0;
    int ovr = 0;
    w0 = t0[0]; w1 = t1[0];
    @(negedge clk) begin dout_ready = 1'b1; cont_en = 1'b1; end
    @(posedge clk); #1;
    for (int f = 0; f < 3; f++) begin
      while (dout_valid !== 1'b1 && n < 1000) begin
        @(posedge clk); #1; n++;
        if (overrun === 1'b1) ovr++;
      end
      stamp[f] = n;
      total++;
      if (dout !== ex[f]) begin bad++; $display("FAIL b2b dout f%0d: got %h want %h", f, dout, ex[f]); end
      if (f < 2) begin w0 = t0[f+1]; w1 = t1[f+1]; end
      else cont_en = 1'b0;
      @(posedge clk); #1; n++;
      if (overrun === 1'b1) ovr++;
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL b2b pulse f%0d: valid=%b want 0", f, dout_valid); end
    end
    total++;
    if (stamp[0] != 132) begin bad++; $display("FAIL b2b first: got %0d want 132", stamp[0]); end
    total++;
    if (stamp[1] - stamp[0] != 140 || stamp[2] - stamp[1] != 140) begin
      bad++; $display("FAIL b2b period: got %0d,%0d want 140,140",
                      stamp[1] - stamp[0], stamp[2] - stamp[1]);
    end
    wait_idle("b2b");
    total++;
    if (ovr != 0) begin bad++; $display("FAIL b2b overrun: got %0d want 0", ovr); end
    dout_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int ovr = 0;
    int os [2] = '{0, 0};
    int drops = 0;
    w0 = 16'h0111; w1 = 16'h0222;
    @(negedge clk) begin dout_ready = 1'b0; cont_en = 1'b1; end
    @(posedge clk); #1;
    for (int n = 1; n <= 415; n++) begin
      @(posedge clk); #1;
      if (overrun === 1'b1) begin
        if (ovr < 2) os[ovr] = n;
        ovr++;
      end
      if (n >= 132 && dout_valid !== 1'b1) drops++;
      if (n == 133) begin w0 = 16'hFFFF; w1 = 16'hEEEE; end
    end
    cont_en = 1'b0;
    wait_idle("overrun");
    total++;
    if (ovr != 2) begin bad++; $display("FAIL overrun count: got %0d want 2", ovr); end
    total++;
    if (os[0] != 272 || os[1] != 412) begin
      bad++; $display("FAIL overrun timing: got %0d,%0d want 272,412", os[0], os[1]);
    end
    total++;
    if (drops != 0) begin bad++; $display("FAIL overrun valid held: drops=%0d want 0", drops); end
    total++;
    if (dout !== 24'h222111) begin bad++; $display("FAIL overrun dout: got %h want 222111", dout); end
    @(negedge clk) dout_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dout_valid !== 1'b0 || dout !== 24'h222111 || overrun !== 1'b0) begin
      bad++; $display("FAIL late consume: valid=%b dout=%h ovr=%b want 0 222111 0",
                      dout_valid, dout, overrun);
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int ovr = 0;
    w0 = 16'h5A5A; w1 = 16'h3C3C;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (dout_valid !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (dout !== 24'hC3CA5A) begin bad++; $display("FAIL pre-reset dout: got %h want c3ca5a", dout); end
    wait_idle("pre-reset");
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (59) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({adc_cs_n, adc_sclk, dout_valid, overrun, busy} !== 5'b11000) begin
      bad++;
      $display("FAIL mid reset: cs_n,sclk,valid,ovr,busy=%b want 11000",
               {adc_cs_n, adc_sclk, dout_valid, overrun, busy});
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (overrun === 1'b1 || dout_valid === 1'b1 || busy === 1'b1) ovr++;
    end
    total++;
    if (ovr != 0) begin bad++; $display("FAIL post-reset quiet: events=%0d want 0", ovr); end
    w0 = 16'h0BEE; w1 = 16'h0CAF;
    n = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (dout_valid !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (n != 132 || dout !== 24'hCAFBEE) begin
      bad++; $display("FAIL restart: lat=%0d dout=%h want 132 cafbee", n, dout);
    end
    @(negedge clk) dout_ready = 1'b1;
    @(posedge clk); #1 dout_ready = 1'b0;
    wait_idle("restart");
  endtask

  task automatic test_cont_drop();
    int vat = 0;
    logic [23:0] got = '0;
    logic cs131 = 1'b1;
    logic [1:0] q133 = '0;
    logic b139 = 1'b0;
    logic b140 = 1'b1;
    logic b160 = 1'b1;
    w0 = 16'hE001; w1 = 16'h1FFE;
    @(negedge clk) begin dout_ready = 1'b1; cont_en = 1'b1; end
    @(posedge clk); #1;
    for (int n = 1; n <= 160; n++) begin
      @(posedge clk); #1;
      if (n == 50) cont_en = 1'b0;
      if (n == 70) start = 1'b1;
      if (n == 71) start = 1'b0;
      if (dout_valid === 1'b1 && vat == 0) begin vat = n; got = dout; end
      if (n == 131) cs131 = adc_cs_n;
      if (n == 133) q133 = {adc_cs_n, adc_sclk};
      if (n == 139) b139 = busy;
      if (n == 140) b140 = busy;
      if (n == 160) b160 = busy;
    end
    total++;
    if (vat != 132 || got !== 24'hFFE001) begin
      bad++; $display("FAIL drop frame: at=%0d dout=%h want 132 ffe001", vat, got);
    end
    total++;
    if (cs131 !== 1'b0 || q133 !== 2'b11) begin
      bad++; $display("FAIL drop cs: cs131=%b q133=%b want 0 11", cs131, q133);
    end
    total++;
    if (b139 !== 1'b1 || b140 !== 1'b0 || b160 !== 1'b0) begin
      bad++; $display("FAIL drop busy: %b%b%b want 100", b139, b140, b160);
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_sweep();
    int n = 0;
    int s1;
    pw = 16'hC3A5;
    @(negedge clk) begin p_ready = 1'b1; p_cont_en = 1'b1; end
    @(posedge clk); #1;
    while (p_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    s1 = n;
    total++;
    if (s1 != 33 || p_dout !== 16'hC3A5) begin
      bad++; $display("FAIL sweep first: lat=%0d dout=%h want 33 c3a5", s1, p_dout);
    end
    pw = 16'h5A3C;
    @(posedge clk); #1; n++;
    while (p_valid !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    p_cont_en = 1'b0;
    total++;
    if (n - s1 != 41 || p_dout !== 16'h5A3C) begin
      bad++; $display("FAIL sweep second: period=%0d dout=%h want 41 5a3c", n - s1, p_dout);
    end
    repeat (60) @(posedge clk);
    #1;
    total++;
    if (p_busy !== 1'b0 || p_overrun !== 1'b0) begin
      bad++; $display("FAIL sweep idle: busy=%b ovr=%b want 0 0", p_busy, p_overrun);
    end
    p_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_cont_drop();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/receive_adc_multi.md
RECEIVE_ADC_MULTI -- requirements
Module: receive_adc_multi

Interface
REQ-001 Parameter DATA_W, default 12: conversion result width per channel.
REQ-002 Parameter FRAME_BITS, default 16: adc_sclk periods per frame, DATA_W <= FRAME_BITS <= 32.
REQ-003 Parameter N_CH, default 2: parallel serial-data lanes sharing one adc_sclk and adc_cs_n, 1 to 8.
REQ-004 Parameter CLK_DIV, default 4: clk cycles per adc_sclk half-period, >= 1.
REQ-005 Parameter QUIET_CYC, default 8: clk cycles adc_cs_n held high between frames, >= 1.
REQ-006 clk  input  1  single system clock; all state updates on rising edge; one clock, no other clock domain.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  single-shot conversion request, sampled only in IDLE.
REQ-009 cont_en  input  1  continuous-conversion mode enable.
REQ-010 sdata  input  N_CH  serial data from each ADC, MSB first; lane i feeds channel i.
REQ-011 adc_sclk  output  1  serial clock to ADCs, idles high.
REQ-012 adc_cs_n  output  1  chip select to ADCs, active-low.
REQ-013 dout  output  N_CH*DATA_W  results; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-014 dout_valid  output  1  dout holds an unconsumed result.
REQ-015 dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-016 overrun  output  1  one-cycle pulse: completed frame discarded.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, SHIFT, QUIET.
REQ-019 IDLE: adc_cs_n=1, adc_sclk=1; go to SETUP when start=1 or cont_en=1.
REQ-020 SETUP: adc_cs_n=0, adc_sclk=1 for exactly CLK_DIV cycles, then SHIFT.
REQ-021 SHIFT: adc_cs_n=0; each bit period = CLK_DIV cycles adc_sclk low then CLK_DIV cycles high; exactly FRAME_BITS periods.
REQ-022 Each lane's sdata SHALL be shifted in on the clk edge where adc_sclk goes low-to-high (mid-bit); N_CH shift registers of FRAME_BITS bits.
REQ-023 Result per channel SHALL be the last DATA_W bits shifted (leading FRAME_BITS-DATA_W bits discarded).
REQ-024 After the final high half-period, go to QUIET: adc_cs_n=1, adc_sclk=1 for QUIET_CYC cycles.
REQ-025 End of QUIET: cont_en=1 -> SETUP; else IDLE.
REQ-026 Frame period SHALL be CLK_DIV + 2*CLK_DIV*FRAME_BITS + QUIET_CYC clk cycles (defaults: 140).
REQ-027 start or cont_en changes outside IDLE/QUIET-end SHALL NOT abort a frame; cont_en dropped mid-frame -> frame completes, then IDLE.
REQ-028 Frame completion (cycle after last high half-period ends): if dout_valid=0, or dout_valid=1 and dout_ready=1 that cycle, dout loads all channels and dout_valid=1 next cycle.
REQ-029 Frame completion with dout_valid=1 and dout_ready=0: new result discarded, dout unchanged, overrun=1 for one cycle.
REQ-030 dout_valid=1 and dout_ready=1 with no completing frame: dout_valid=0 next cycle; dout holds last value.
REQ-031 dout SHALL change only on a load; dout_valid SHALL NOT drop without dout_ready.
REQ-032 Bit counter and divider SHALL wrap cleanly; no extra or missing adc_sclk pulse at frame boundaries.

Reset
REQ-033 rst=0 at a clk edge SHALL force: state IDLE, adc_cs_n=1, adc_sclk=1, dout=0, dout_valid=0, overrun=0, busy=0, counters and shift registers 0.
REQ-034 rst asserted mid-frame SHALL abort immediately; no partial result loaded, no overrun pulse.
REQ-035 After rst release, no frame SHALL start until start=1 or cont_en=1 is sampled in IDLE.

Verification
REQ-036 Defaults, start pulse, lane0 model drives 0000_1010_1100_0011, lane1 1111_0101_0011_1100 -> dout=0x53C_AC3 (ch1=0x53C, ch0=0xAC3), dout_valid after 132 cycles, 16 adc_sclk rising edges counted.
REQ-037 cont_en=1, dout_ready=1 always -> frames every 140 cycles, one dout_valid pulse per frame, overrun never set.
REQ-038 cont_en=1, dout_ready=0 for 3 frames -> dout keeps frame-1 value, overrun pulses twice, dout_valid stays 1.
REQ-039 rst=0 at cycle 60 of a frame -> next cycle adc_cs_n=1, adc_sclk=1, dout_valid=0, no overrun; restart with start yields correct data.
REQ-040 cont_en dropped during SHIFT -> frame completes with valid data, QUIET, then IDLE with busy=0.
REQ-041 Parameter sweep N_CH=1, DATA_W=FRAME_BITS=16, CLK_DIV=1 -> 16-bit result correct, frame period 1+32+8=41 cycles.
